// File: rtl/uart_host_responder.sv
// uart_host_responder: request/response engine over a 16-word register file with burst write and streamed burst read.
module uart_host_responder #(
  parameter logic [15:0] CMD_PING  = 16'h0000,
  parameter logic [15:0] CMD_WRITE = 16'h0001,
  parameter logic [15:0] CMD_READ  = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ih_ready,
  output logic        o_master_ready,
  input  logic [31:0] i_in_command,
  input  logic [31:0] i_in_address,
  input  logic [31:0] i_in_data,
  input  logic [27:0] i_in_data_count,
  input  logic        i_oh_ready,
  output logic        o_oh_en,
  output logic [31:0] o_out_status,
  output logic [31:0] o_out_address,
  output logic [31:0] o_out_data,
  output logic [27:0] o_out_data_count
);
  typedef enum logic [1:0] {IDLE, WR_COLLECT, RESP, RD_STREAM} state_t;
  state_t state, state_nx;
  logic [31:0] mem [16];
  logic [31:0] cmd_q, addr_q, c_cmd, c_addr;
  logic [27:0] n_q, off, c_n, n_in;
  logic err_q, en_q, c_err, err_in, idle, take, c_write, c_read, last_wr, we, enter_resp;
  logic [3:0] widx, ridx;
  // c_* select the live request inputs in IDLE and the latched request otherwise
  always_comb begin
    idle = state == IDLE;
    o_master_ready = idle || state == WR_COLLECT;
    take = i_ih_ready && o_master_ready;
    o_oh_en = (state == RESP || state == RD_STREAM) && i_oh_ready && !en_q;
    n_in = i_in_data_count == 28'd0 ? 28'd1 : i_in_data_count;
    err_in = |i_in_address[31:4] || !(i_in_command[15:0] == CMD_PING ||
             i_in_command[15:0] == CMD_WRITE || i_in_command[15:0] == CMD_READ);
    c_cmd = idle ? i_in_command : cmd_q;
    c_addr = idle ? i_in_address : addr_q;
    c_n = idle ? n_in : n_q;
    c_err = idle ? err_in : err_q;
    c_write = c_cmd[15:0] == CMD_WRITE;
    c_read = c_cmd[15:0] == CMD_READ && !c_err;
    last_wr = idle ? c_n == 28'd1 : off == n_q - 28'd1;
    we = take && c_write && !c_err;
    widx = c_addr[3:0] + (idle ? 4'd0 : off[3:0]);
    ridx = addr_q[3:0] + (state == RESP ? 4'd1 : off[3:0] + 4'd1);
    state_nx = state;
    if (idle && take) state_nx = c_write && !last_wr ? WR_COLLECT : RESP;
    if (state == WR_COLLECT && take && last_wr) state_nx = RESP;
    if (state == RESP && o_oh_en) state_nx = c_read && n_q > 28'd1 ? RD_STREAM : IDLE;
    if (state == RD_STREAM && o_oh_en && off == n_q - 28'd1) state_nx = IDLE;
    enter_resp = state_nx == RESP && state != RESP;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      off <= 28'd0;
      en_q <= 1'b0;
      cmd_q <= 32'h0;
      addr_q <= 32'h0;
      n_q <= 28'd0;
      err_q <= 1'b0;
      o_out_status <= 32'h0;
      o_out_address <= 32'h0;
      o_out_data <= 32'h0;
      o_out_data_count <= 28'h0;
    end else begin
      state <= state_nx;
      en_q <= o_oh_en;
      if (idle && take) begin
        cmd_q <= i_in_command;
        addr_q <= i_in_address;
        n_q <= n_in;
        err_q <= err_in;
        off <= 28'd1;
      end else if (state == WR_COLLECT && take) begin
        off <= off + 28'd1;
      end else if (o_oh_en && state_nx == RD_STREAM) begin
        off <= state == RESP ? 28'd1 : off + 28'd1;
        o_out_data <= mem[ridx];
      end
      if (enter_resp) begin
        o_out_status <= {~c_cmd[31] & ~c_err, ~c_cmd[30:0]};
        o_out_address <= c_addr;
        o_out_data_count <= c_read ? c_n : 28'd1;
        o_out_data <= c_err ? 32'h0 : c_write ? {4'h0, c_n} : c_read ? mem[c_addr[3:0]] : 32'h0;
      end
    end
  end
  // register file keeps its contents across reset
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= i_in_data;
  end
endmodule

// File: tb/tb_uart_host_responder.sv
// tb_uart_host_responder: table-driven requests with a response scoreboard, plus backpressure and mid-stream reset sequences.
module tb_uart_host_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic i_ih_ready = 1'b0, o_master_ready, i_oh_ready = 1'b1, o_oh_en;
  logic [31:0] i_in_command = 32'h0, i_in_address = 32'h0, i_in_data = 32'h0;
  logic [27:0] i_in_data_count = 28'd0;
  logic [31:0] o_out_status, o_out_address, o_out_data;
  logic [27:0] o_out_data_count;

  uart_host_responder dut (
    .clk(clk), .rst(rst), .i_ih_ready(i_ih_ready), .o_master_ready(o_master_ready),
    .i_in_command(i_in_command), .i_in_address(i_in_address), .i_in_data(i_in_data),
    .i_in_data_count(i_in_data_count), .i_oh_ready(i_oh_ready), .o_oh_en(o_oh_en),
    .o_out_status(o_out_status), .o_out_address(o_out_address), .o_out_data(o_out_data),
    .o_out_data_count(o_out_data_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] st, ad, da; logic [27:0] ct; } exp_t;
  typedef struct { logic [31:0] cmd, addr; logic [27:0] cnt; logic [2:0][31:0] w; logic err; logic [31:0] st; } vec_t;

  exp_t q[$];
  vec_t vt[13];
  logic [31:0] mem_m [16];
  int vectors = 0, miscompares = 0, pulses = 0;
  logic prev_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push(logic [31:0] st, logic [31:0] ad, logic [31:0] da, logic [27:0] ct);
    exp_t e;
    e.st = st; e.ad = ad; e.da = da; e.ct = ct;
    q.push_back(e);
  endtask

  function automatic vec_t mk(logic [31:0] cmd, logic [31:0] addr, logic [27:0] cnt,
                              logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic err, logic [31:0] st);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.cnt = cnt; v.w = {w2, w1, w0}; v.err = err; v.st = st;
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (o_oh_en) begin
      pulses++;
      chk("oh_en_gap", {31'd0, prev_en}, 32'd0);
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_oh_en: got data %h want no response", o_out_data);
      end else begin
        e = q.pop_front();
        chk("status", o_out_status, e.st);
        chk("address", o_out_address, e.ad);
        chk("data", o_out_data, e.da);
        chk("data_count", {4'h0, o_out_data_count}, {4'h0, e.ct});
      end
    end
    prev_en = o_oh_en;
  end

  task automatic wait_drain(string name);
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending responses want 0", name, q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic apply(vec_t v);
    int n = (v.cnt == 28'd0) ? 1 : int'(v.cnt);
    int np = (v.cmd[15:0] == 16'h0001) ? n : 1;
    logic [3:0] ix;
    int t = 0;
    while (!o_master_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (v.err || v.cmd[15:0] == 16'h0000) push(v.st, v.addr, 32'h0, 28'd1);
    else if (v.cmd[15:0] == 16'h0001) begin
      push(v.st, v.addr, n, 28'd1);
      for (int k = 0; k < n; k++) begin
        ix = v.addr[3:0] + 4'(k);
        mem_m[ix] = v.w[k];
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        ix = v.addr[3:0] + 4'(k);
        push(v.st, v.addr, mem_m[ix], v.cnt == 28'd0 ? 28'd1 : v.cnt);
      end
    end
    for (int k = 0; k < np; k++) begin
      chk("master_ready_pulse", {31'd0, o_master_ready}, 32'd1);
      i_ih_ready = 1'b1;
      i_in_command = v.cmd;
      i_in_address = v.addr;
      i_in_data_count = v.cnt;
      i_in_data = v.w[k];
      @(posedge clk); #1;
    end
    i_ih_ready = 1'b0;
    wait_drain("response");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int t, base;
    vt[0]  = mk(32'h0, 32'h0,  28'd0, 32'h0,  32'h0,  32'h0,  1'b0, 32'hFFFF_FFFF);
    vt[1]  = mk(32'h1, 32'h4,  28'd3, 32'h11, 32'h22, 32'h33, 1'b0, 32'hFFFF_FFFE);
    vt[2]  = mk(32'h2, 32'h4,  28'd3, 32'h0,  32'h0,  32'h0,  1'b0, 32'hFFFF_FFFD);
    vt[3]  = mk(32'h1, 32'hF,  28'd2, 32'hAA, 32'hBB, 32'h0,  1'b0, 32'hFFFF_FFFE);
    vt[4]  = mk(32'h2, 32'h0,  28'd1, 32'h0,  32'h0,  32'h0,  1'b0, 32'hFFFF_FFFD);
    vt[5]  = mk(32'h1, 32'h10, 28'd3, 32'h1,  32'h2,  32'h3,  1'b1, 32'h7FFF_FFFE);
    vt[6]  = mk(32'h2, 32'h0,  28'd1, 32'h0,  32'h0,  32'h0,  1'b0, 32'hFFFF_FFFD);
    vt[7]  = mk(32'h2, 32'h4,  28'd3, 32'h0,  32'h0,  32'h0,  1'b0, 32'hFFFF_FFFD);
    vt[8]  = mk(32'h7, 32'h0,  28'd0, 32'h0,  32'h0,  32'h0,  1'b1, 32'h7FFF_FFF8);
    vt[9]  = mk(32'h2, 32'h4,  28'd0, 32'h0,  32'h0,  32'h0,  1'b0, 32'hFFFF_FFFD);
    vt[10] = mk(32'h2, 32'h20, 28'd3, 32'h0,  32'h0,  32'h0,  1'b1, 32'h7FFF_FFFD);
    vt[11] = mk(32'h1, 32'h3,  28'd1, 32'h55, 32'h0,  32'h0,  1'b0, 32'hFFFF_FFFE);
    vt[12] = mk(32'h2, 32'h3,  28'd2, 32'h0,  32'h0,  32'h0,  1'b0, 32'hFFFF_FFFD);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_master_ready", {31'd0, o_master_ready}, 32'd1);
    chk("rst_oh_en", {31'd0, o_oh_en}, 32'd0);
    chk("rst_status", o_out_status, 32'h0);
    chk("rst_address", o_out_address, 32'h0);
    chk("rst_data", o_out_data, 32'h0);
    chk("rst_data_count", {4'h0, o_out_data_count}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) apply(vt[i]);

    // backpressure: response held in RESP while i_oh_ready is low
    i_oh_ready = 1'b0;
    push(32'hFFFF_FFFF, 32'h5, 32'h0, 28'd1);
    i_ih_ready = 1'b1; i_in_command = 32'h0; i_in_address = 32'h5; i_in_data_count = 28'd0;
    @(posedge clk); #1;
    i_ih_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_oh_en", {31'd0, o_oh_en}, 32'd0);
      chk("bp_status", o_out_status, 32'hFFFF_FFFF);
      chk("bp_address", o_out_address, 32'h5);
      chk("bp_master_ready", {31'd0, o_master_ready}, 32'd0);
    end
    @(posedge clk); #1;
    i_oh_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_oh_en", {31'd0, o_oh_en}, 32'd1);
    wait_drain("bp");

    // reset in the middle of an 8-word read stream
    base = pulses;
    for (int k = 0; k < 3; k++) push(32'hFFFF_FFFD, 32'h4, mem_m[4 + k], 28'd8);
    i_ih_ready = 1'b1; i_in_command = 32'h2; i_in_address = 32'h4; i_in_data_count = 28'd8;
    @(posedge clk); #1;
    i_ih_ready = 1'b0;
    t = 0;
    while (pulses - base < 3 && t < 100) begin
      @(negedge clk); #1; t++;
    end
    chk("stream_words_before_rst", pulses - base, 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_master_ready", {31'd0, o_master_ready}, 32'd1);
    chk("mid_rst_oh_en", {31'd0, o_oh_en}, 32'd0);
    chk("mid_rst_status", o_out_status, 32'h0);
    chk("mid_rst_address", o_out_address, 32'h0);
    chk("mid_rst_data", o_out_data, 32'h0);
    chk("mid_rst_data_count", {4'h0, o_out_data_count}, 32'h0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    apply(vt[0]);
    apply(vt[7]);
    chk("final_queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
